// File: rtl/pla_vector_source.sv
// rtl/pla_vector_source.sv - vector stream source and in-order response checker for PLA minterm detectors
module pla_vector_source #(
  parameter int              N_IN      = 15,
  parameter logic [N_IN-1:0] TARGET    = 15'h0040,
  parameter logic [N_IN-1:0] LFSR_SEED = 15'h7FFF,
  parameter int              QDEPTH    = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [1:0]      i_mode,
  input  logic [15:0]     i_count_limit,
  output logic            o_vec_valid,
  input  logic            i_vec_ready,
  output logic [N_IN-1:0] o_vec_data,
  output logic            o_vec_last,
  input  logic            i_resp_valid,
  input  logic            i_resp_y,
  output logic            o_busy,
  output logic            o_done,
  output logic [15:0]     o_hit_count,
  output logic [15:0]     o_mism_count,
  output logic            o_error
);

  // Counter width must hold both 2^N_IN (clamped exhaustive count) and a 16-bit limit.
  localparam int CW = (N_IN + 1 > 17) ? N_IN + 1 : 17;
  localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int SW = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic [CW-1:0]   EXH_MAX   = CW'(1) << N_IN;
  localparam logic [N_IN-1:0] LFSR_TAPS = N_IN'(16'h6000);
  localparam logic [QW:0]     Q_FULL    = (QW+1)'(QDEPTH);

  localparam logic [1:0] MODE_EXH  = 2'd0;
  localparam logic [1:0] MODE_WALK = 2'd1;
  localparam logic [1:0] MODE_LFSR = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Run configuration and generator state
  logic [1:0]      r_mode;
  logic [CW-1:0]   r_total;
  logic [CW-1:0]   r_idx;
  logic [N_IN-1:0] r_lfsr;

  // Presented vector
  logic            r_vec_valid;
  logic [N_IN-1:0] r_vec_data;
  logic            r_vec_last;

  // Golden-bit queue of outstanding responses
  logic            r_q [QDEPTH];
  logic [QW-1:0]   r_q_wr;
  logic [QW-1:0]   r_q_rd;
  logic [QW:0]     r_q_cnt;

  // Scoreboard
  logic [15:0]     r_hit;
  logic [15:0]     r_mism;
  logic            r_error;

  logic            w_start_ok;
  logic [CW-1:0]   w_limit_ext;
  logic [CW-1:0]   w_start_total;
  logic            w_xfer;
  logic            w_push;
  logic            w_push_bit;
  logic            w_q_empty;
  logic            w_pop;
  logic            w_pop_bit;
  logic            w_spurious;
  logic [QW:0]     w_q_cnt_next;
  logic            w_more;
  logic            w_load;
  logic [SW-1:0]   w_bit_sel;
  logic [N_IN-1:0] w_next_vec;
  logic            w_next_last;
  logic [N_IN-1:0] w_lfsr_step;

  assign w_start_ok  = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_limit_ext = CW'(i_count_limit);

  assign w_xfer      = r_vec_valid && i_vec_ready;
  assign w_push      = w_xfer;
  assign w_push_bit  = (r_vec_data == TARGET);
  assign w_q_empty   = (r_q_cnt == '0);
  // An empty queue can still be popped when the matching vector is pushed in the same cycle.
  assign w_pop       = i_resp_valid && (!w_q_empty || w_push);
  assign w_pop_bit   = w_q_empty ? w_push_bit : r_q[r_q_rd];
  assign w_spurious  = i_resp_valid && w_q_empty && !w_push;
  assign w_q_cnt_next = r_q_cnt + (QW+1)'(w_push) - (QW+1)'(w_pop);

  // A new vector is only offered if its golden bit is guaranteed a queue slot at transfer.
  assign w_more      = (r_idx < r_total);
  assign w_load      = (r_state == ST_RUN) && (!r_vec_valid || w_xfer) && w_more &&
                       (w_q_cnt_next < Q_FULL);

  assign w_bit_sel   = SW'(r_idx - CW'(1));
  assign w_next_last = (r_idx == (r_total - CW'(1)));
  assign w_lfsr_step = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);

  // Number of vectors a run will issue, decided from the inputs seen with start
  always_comb begin
    w_start_total = '0;
    case (i_mode)
      MODE_EXH:  w_start_total = (w_limit_ext > EXH_MAX) ? EXH_MAX : w_limit_ext;
      MODE_WALK: w_start_total = CW'(N_IN + 1);
      MODE_LFSR: w_start_total = w_limit_ext;
      default:   w_start_total = '0;
    endcase
  end

  // Value of the next vector to present, selected by the latched mode
  always_comb begin
    w_next_vec = '0;
    case (r_mode)
      MODE_EXH:  w_next_vec = N_IN'(r_idx);
      MODE_WALK: w_next_vec = (r_idx == '0) ? TARGET : (TARGET ^ (N_IN'(1) << w_bit_sel));
      MODE_LFSR: w_next_vec = r_lfsr;
      default:   w_next_vec = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start_ok) begin
          if ((i_mode == MODE_RSVD) || (w_start_total == '0)) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (w_xfer && r_vec_last) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_q_cnt_next == '0) begin
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Vector generator: latch run config on start, present and hold vectors until accepted
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode      <= MODE_EXH;
      r_total     <= '0;
      r_idx       <= '0;
      r_lfsr      <= LFSR_SEED;
      r_vec_valid <= 1'b0;
      r_vec_data  <= '0;
      r_vec_last  <= 1'b0;
    end else if (w_start_ok) begin
      r_mode      <= i_mode;
      r_total     <= w_start_total;
      r_idx       <= '0;
      r_lfsr      <= LFSR_SEED;
      r_vec_valid <= 1'b0;
      r_vec_last  <= 1'b0;
    end else if (w_load) begin
      r_vec_valid <= 1'b1;
      r_vec_data  <= w_next_vec;
      r_vec_last  <= w_next_last;
      r_idx       <= r_idx + CW'(1);
      if (r_mode == MODE_LFSR) begin
        r_lfsr <= w_lfsr_step;
      end
    end else if (w_xfer) begin
      r_vec_valid <= 1'b0;
      r_vec_last  <= 1'b0;
    end
  end

  // Golden-bit storage; occupancy is tracked separately so the slots need no reset
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q[r_q_wr] <= w_push_bit;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (i_rst || w_start_ok) begin
      r_q_wr  <= '0;
      r_q_rd  <= '0;
      r_q_cnt <= '0;
    end else begin
      if (w_push) begin
        r_q_wr <= r_q_wr + QW'(1);
      end
      if (w_pop) begin
        r_q_rd <= r_q_rd + QW'(1);
      end
      r_q_cnt <= w_q_cnt_next;
    end
  end

  // Response scoreboard: saturating hit/mismatch counts and sticky error
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hit   <= '0;
      r_mism  <= '0;
      r_error <= 1'b0;
    end else if (w_start_ok) begin
      r_hit   <= '0;
      r_mism  <= '0;
      r_error <= (i_mode == MODE_RSVD);
    end else begin
      if (w_pop) begin
        if (i_resp_y && (r_hit != 16'hFFFF)) begin
          r_hit <= r_hit + 16'd1;
        end
        if ((i_resp_y != w_pop_bit) && (r_mism != 16'hFFFF)) begin
          r_mism <= r_mism + 16'd1;
        end
      end
      if (w_spurious) begin
        r_error <= 1'b1;
      end
    end
  end

  assign o_vec_valid  = r_vec_valid;
  assign o_vec_data   = r_vec_data;
  assign o_vec_last   = r_vec_last;
  assign o_busy       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign o_done       = (r_state == ST_DONE);
  assign o_hit_count  = r_hit;
  assign o_mism_count = r_mism;
  assign o_error      = r_error;

endmodule

// File: tb/tb_pla_vector_source.sv
// tb/tb_pla_vector_source.sv - self-checking bench for pla_vector_source
module tb_pla_vector_source;
  localparam int          N_IN   = 15;
  localparam logic [14:0] TARGET = 15'h0040;
  localparam logic [14:0] SEED   = 15'h7FFF;
  localparam int          QDEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  mode;
  logic [15:0] count_limit;
  logic        vec_valid, vec_ready, vec_last;
  logic [14:0] vec_data;
  logic        resp_valid, resp_y;
  logic        busy, done, error;
  logic [15:0] hit_count, mism_count;

  always #5 clk = ~clk;

  pla_vector_source dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_mode       (mode),
    .i_count_limit(count_limit),
    .o_vec_valid  (vec_valid),
    .i_vec_ready  (vec_ready),
    .o_vec_data   (vec_data),
    .o_vec_last   (vec_last),
    .i_resp_valid (resp_valid),
    .i_resp_y     (resp_y),
    .o_busy       (busy),
    .o_done       (done),
    .o_hit_count  (hit_count),
    .o_mism_count (mism_count),
    .o_error      (error)
  );

  typedef struct {
    string      nm;
    logic [1:0] mode;
    int         limit;
    int         kind;     // 0 ideal, 1 stuck 1, 2 stuck 0, 3 random y
    int         lat;
    int         rdy;      // 0 always ready, 1 random, 2 hold low 5 cycles
    int         exp_n;
    int         exp_hit;  // -1: rely on model only
    int         exp_mism;
    int         exp_err;
  } case_t;

  typedef struct {
    int   due;
    logic y;
  } pend_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  case_t       tbl[11];
  pend_t       pend[$];
  logic [14:0] got[$];
  logic [14:0] exp_q[$];
  int          cyc = 0;
  int          lat = 1, kind = 0, rdy_mode = 0;
  int          hold_cnt, stab_err, max_out, last_pos, n_last, mdl_hit, mdl_mism;
  logic        prev_hold = 1'b0;
  logic [14:0] prev_data;
  logic        prev_last;
  logic        do_start = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int model_count(input logic [1:0] m, input int limit);
    case (m)
      2'd0:    return (limit > 32768) ? 32768 : limit;
      2'd1:    return N_IN + 1;
      2'd2:    return limit;
      default: return 0;
    endcase
  endfunction

  task automatic build_exp(input logic [1:0] m, input int n);
    logic [14:0] l;
    exp_q.delete();
    l = SEED;
    for (int k = 0; k < n; k++) begin
      case (m)
        2'd0:    exp_q.push_back(15'(k));
        2'd1:    exp_q.push_back((k == 0) ? TARGET : (TARGET ^ (15'(1) << (k - 1))));
        default: begin
          exp_q.push_back(l);
          l = (l % 2 == 1) ? ((l / 2) ^ 15'h6000) : (l / 2);
        end
      endcase
    end
  endtask

  // One clock cycle of detector/ready behaviour, acting at the falling edge
  task automatic step();
    logic y, g;
    @(negedge clk);
    cyc++;
    start = do_start;
    do_start = 1'b0;
    if (prev_hold && !(vec_valid === 1'b1 && vec_data === prev_data && vec_last === prev_last))
      stab_err++;
    case (rdy_mode)
      0: vec_ready = 1'b1;
      1: vec_ready = 1'($urandom_range(0, 1));
      default: begin
        if (got.size() == 5 && hold_cnt < 5) begin
          vec_ready = 1'b0;
          hold_cnt++;
        end else begin
          vec_ready = 1'b1;
        end
      end
    endcase
    resp_valid = 1'b0;
    resp_y = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      resp_valid = 1'b1;
      resp_y = pend[0].y;
      void'(pend.pop_front());
    end
    if (vec_valid === 1'b1 && vec_ready) begin
      g = (vec_data == TARGET);
      case (kind)
        0:       y = g;
        1:       y = 1'b1;
        2:       y = 1'b0;
        default: y = 1'($urandom_range(0, 1));
      endcase
      got.push_back(vec_data);
      if (vec_last) begin
        n_last++;
        last_pos = got.size() - 1;
      end
      pend.push_back('{cyc + lat, y});
      if (y) mdl_hit++;
      if (y != g) mdl_mism++;
    end
    if (pend.size() > max_out) max_out = pend.size();
    prev_hold = (vec_valid === 1'b1) && !vec_ready;
    prev_data = vec_data;
    prev_last = vec_last;
  endtask

  task automatic clear_case();
    got.delete();
    pend.delete();
    hold_cnt = 0; stab_err = 0; max_out = 0; last_pos = -1; n_last = 0;
    mdl_hit = 0; mdl_mism = 0; prev_hold = 1'b0;
  endtask

  task automatic run_case(input case_t c);
    int t, n;
    mode = c.mode; count_limit = 16'(c.limit);
    kind = c.kind; lat = c.lat; rdy_mode = c.rdy;
    clear_case();
    n = model_count(c.mode, c.limit);
    build_exp(c.mode, n);
    do_start = 1'b1;
    step();
    step();
    t = 1;
    if (n > 0) check({c.nm, "_busy"}, 32'(busy), 1);
    else       check({c.nm, "_done_next"}, 32'(done), 1);
    while (done !== 1'b1 && t < 40000) begin
      step();
      t++;
    end
    check({c.nm, "_done"}, 32'(done), 1);
    check({c.nm, "_count"}, got.size(), n);
    if (c.exp_n >= 0) check({c.nm, "_count_tbl"}, got.size(), c.exp_n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL %s_vec[%0d]: got %0h expected %0h", c.nm, i, got[i], exp_q[i]);
      end
    end
    if (n > 0) begin
      check({c.nm, "_last_pos"}, last_pos, n - 1);
      check({c.nm, "_last_cnt"}, n_last, 1);
    end
    check({c.nm, "_hit_model"}, 32'(hit_count), mdl_hit);
    check({c.nm, "_mism_model"}, 32'(mism_count), mdl_mism);
    if (c.exp_hit >= 0) begin
      check({c.nm, "_hit"}, 32'(hit_count), c.exp_hit);
      check({c.nm, "_mism"}, 32'(mism_count), c.exp_mism);
    end
    check({c.nm, "_error"}, 32'(error), c.exp_err);
    check({c.nm, "_busy_end"}, 32'(busy), 0);
    check({c.nm, "_valid_end"}, 32'(vec_valid), 0);
    check({c.nm, "_stable"}, stab_err, 0);
    check({c.nm, "_outstanding"}, 32'(max_out <= QDEPTH), 1);
  endtask

  initial begin
    case_t rc;
    tbl[0]  = '{"m0_lim4",      2'd0, 4,     0, 1, 0, 4,     0,  0,  0};
    tbl[1]  = '{"m1_ideal",     2'd1, 0,     0, 1, 0, 16,    1,  0,  0};
    tbl[2]  = '{"m1_stuck1",    2'd1, 0,     1, 1, 0, 16,    16, 15, 0};
    tbl[3]  = '{"m0_hold",      2'd0, 40,    0, 1, 2, 40,    0,  0,  0};
    tbl[4]  = '{"m0_lat6",      2'd0, 100,   0, 6, 0, 100,   1,  0,  0};
    tbl[5]  = '{"m2_lim3",      2'd2, 3,     0, 2, 0, 3,     0,  0,  0};
    tbl[6]  = '{"m1_stuck0",    2'd1, 0,     2, 4, 1, 16,    0,  1,  0};
    tbl[7]  = '{"m2_rnd",       2'd2, 50,    3, 3, 1, 50,    -1, -1, 0};
    tbl[8]  = '{"m0_lim0",      2'd0, 0,     0, 1, 0, 0,     0,  0,  0};
    tbl[9]  = '{"m3_reserved",  2'd3, 5,     0, 1, 0, 0,     0,  0,  1};
    tbl[10] = '{"m0_clamp",     2'd0, 40000, 0, 1, 0, 32768, 1,  0,  0};

    rst = 1'b1; start = 1'b0; mode = 2'd0; count_limit = 16'd0;
    vec_ready = 1'b0; resp_valid = 1'b0; resp_y = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(vec_valid), 0);
    check("rst_last", 32'(vec_last), 0);
    check("rst_data", 32'(vec_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_hit", 32'(hit_count), 0);
    check("rst_mism", 32'(mism_count), 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_case(tbl[i]);
      if (i == 1) begin
        // spurious response while DONE: error sets, counts keep the last run's values
        @(negedge clk);
        resp_valid = 1'b1; resp_y = 1'b1;
        @(negedge clk);
        resp_valid = 1'b0; resp_y = 1'b0;
        check("spurious_error", 32'(error), 1);
        check("spurious_hit", 32'(hit_count), 1);
        check("spurious_mism", 32'(mism_count), 0);
      end
    end

    // reset in the middle of a run, then late responses arrive to an empty queue
    mode = 2'd0; count_limit = 16'd100; kind = 0; lat = 6; rdy_mode = 0;
    clear_case();
    do_start = 1'b1;
    step();
    repeat (12) step();
    check("midrst_busy_before", 32'(busy), 1);
    @(negedge clk);
    rst = 1'b1; resp_valid = 1'b0; vec_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    prev_hold = 1'b0;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_valid", 32'(vec_valid), 0);
    check("midrst_data", 32'(vec_data), 0);
    check("midrst_hit", 32'(hit_count), 0);
    check("midrst_error_clear", 32'(error), 0);
    check("midrst_inflight", 32'(pend.size() > 0), 1);
    repeat (10) step();
    check("midrst_late_error", 32'(error), 1);
    check("midrst_late_hit", 32'(hit_count), 0);
    check("midrst_late_mism", 32'(mism_count), 0);
    check("midrst_idle", 32'(busy | done), 0);

    // randomized runs checked against the model
    for (int r = 0; r < 5; r++) begin
      rc.nm = $sformatf("rnd%0d", r);
      rc.mode = 2'($urandom_range(0, 2));
      rc.limit = $urandom_range(1, 120);
      rc.kind = 3;
      rc.lat = $urandom_range(1, 6);
      rc.rdy = 1;
      rc.exp_n = -1;
      rc.exp_hit = -1;
      rc.exp_mism = -1;
      rc.exp_err = 0;
      run_case(rc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
